// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   REG_AW_DEF : default register-address width
//   state_e    : controller FSM states
package pipe_pkg;

  localparam int REG_AW_DEF = 5;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_e;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard compare between the ID-stage sources and the EXE-stage load.
// Ports:
//   id_src1_i, id_src2_i : ID-stage source registers
//   id_two_src_i         : ID instruction actually reads src2
//   exe_dest_i           : EXE-stage destination register
//   exe_mem_r_en_i       : EXE instruction is a load
//   load_use_o           : ID must stall one cycle behind the load
module hazard_detect
  import pipe_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic [REG_AW-1:0] id_src1_i,
  input  logic [REG_AW-1:0] id_src2_i,
  input  logic              id_two_src_i,
  input  logic [REG_AW-1:0] exe_dest_i,
  input  logic              exe_mem_r_en_i,
  output logic              load_use_o
);

  logic dest_nz;
  logic hit1;
  logic hit2;

  // r0 is hard-wired zero, so a load into it never feeds a consumer.
  assign dest_nz    = (exe_dest_i != '0);
  assign hit1       = (exe_dest_i == id_src1_i);
  assign hit2       = id_two_src_i && (exe_dest_i == id_src2_i);
  assign load_use_o = exe_mem_r_en_i && dest_nz && (hit1 || hit2);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline.
// Ports:
//   clk_i, rst_i            : clock, synchronous active-high reset
//   id_*/exe_* inputs       : operands for load-use detection
//   branch_taken_i          : EXE resolved a taken branch
//   mem_req_i, mem_ready_i  : MEM-stage access and its completion
//   pc_freeze_o .. memwb_bubble_o : pipeline register enables (combinational)
//   mem_err_o               : sticky memory-timeout flag
//   stall_cnt_o             : saturating count of cycles with pc_freeze_o high
//
// state    | meaning
// RUN      | normal flow; load-use / branch flush / new memory stall decided here
// MEM_WAIT | data memory busy; freeze group held until mem_ready_i
// ERROR    | memory timed out; freeze group held until reset
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int REG_AW      = REG_AW_DEF,
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [REG_AW-1:0] id_src1_i,
  input  logic [REG_AW-1:0] id_src2_i,
  input  logic              id_two_src_i,
  input  logic [REG_AW-1:0] exe_dest_i,
  input  logic              exe_mem_r_en_i,
  input  logic              branch_taken_i,
  input  logic              mem_req_i,
  input  logic              mem_ready_i,
  output logic              pc_freeze_o,
  output logic              ifid_freeze_o,
  output logic              ifid_flush_o,
  output logic              idex_bubble_o,
  output logic              exmem_hold_o,
  output logic              memwb_bubble_o,
  output logic              mem_err_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  localparam int WAIT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

  state_e             state_q, state_d;
  logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic               br_pend_q, br_pend_d;
  logic               mem_err_q, mem_err_d;
  logic [CNT_W-1:0]   stall_cnt_q;
  logic               load_use;
  logic               mem_stall;

  hazard_detect #(.REG_AW(REG_AW)) u_hazard_detect (
    .id_src1_i      (id_src1_i),
    .id_src2_i      (id_src2_i),
    .id_two_src_i   (id_two_src_i),
    .exe_dest_i     (exe_dest_i),
    .exe_mem_r_en_i (exe_mem_r_en_i),
    .load_use_o     (load_use)
  );

  assign mem_stall = mem_req_i && !mem_ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= RUN;
      wait_cnt_q  <= '0;
      br_pend_q   <= 1'b0;
      mem_err_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      br_pend_q  <= br_pend_d;
      mem_err_q  <= mem_err_d;
      if (pc_freeze_o && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    wait_cnt_d     = wait_cnt_q;
    br_pend_d      = br_pend_q;
    mem_err_d      = mem_err_q;
    pc_freeze_o    = 1'b0;
    ifid_freeze_o  = 1'b0;
    ifid_flush_o   = 1'b0;
    idex_bubble_o  = 1'b0;
    exmem_hold_o   = 1'b0;
    memwb_bubble_o = 1'b0;
    if (!rst_i) begin
      unique case (state_q)
        RUN: begin
          if (mem_stall) begin
            // ID/EXE is not bubbled: it holds along with the frozen front end.
            state_d        = MEM_WAIT;
            wait_cnt_d     = WAIT_W'(1);
            pc_freeze_o    = 1'b1;
            ifid_freeze_o  = 1'b1;
            exmem_hold_o   = 1'b1;
            memwb_bubble_o = 1'b1;
            if (branch_taken_i) br_pend_d = 1'b1;
          end else if (branch_taken_i || br_pend_q) begin
            ifid_flush_o  = 1'b1;
            idex_bubble_o = 1'b1;
            br_pend_d     = 1'b0;
          end else if (load_use) begin
            pc_freeze_o   = 1'b1;
            ifid_freeze_o = 1'b1;
            idex_bubble_o = 1'b1;
          end
        end
        MEM_WAIT: begin
          if (branch_taken_i) br_pend_d = 1'b1;
          if (mem_ready_i) begin
            // Stall drops now so the returning data is captured into MEM/WB.
            state_d    = RUN;
            wait_cnt_d = '0;
          end else begin
            pc_freeze_o    = 1'b1;
            ifid_freeze_o  = 1'b1;
            exmem_hold_o   = 1'b1;
            memwb_bubble_o = 1'b1;
            if (wait_cnt_q == WAIT_MAX) begin
              state_d   = ERROR;
              mem_err_d = 1'b1;
            end else begin
              wait_cnt_d = wait_cnt_q + WAIT_W'(1);
            end
          end
        end
        ERROR: begin
          pc_freeze_o    = 1'b1;
          ifid_freeze_o  = 1'b1;
          exmem_hold_o   = 1'b1;
          memwb_bubble_o = 1'b1;
        end
        default: state_d = RUN;
      endcase
    end
  end

  assign mem_err_o   = mem_err_q;
  assign stall_cnt_o = stall_cnt_q;

endmodule
